reg_file_pc: RTL and testbench

Architectural register file and program-counter block of the processor datapath. Holds fifteen 32-bit general registers R0–R14 and a 16-bit program counter aliased as R15. Provides four combinational read ports (Rn, Rs, Rm, Rd) and one synchronous write port. Includes the +1 PC incrementer that feeds the next-PC value back into the PC register every cycle.

---
 rtl/reg_file_pc.sv | 72 +++++++
 tb/tb_reg_file_pc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_pc.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pc
// Description : Fifteen 32-bit general registers plus a 16-bit PC aliased as
//               R15, four combinational read ports, one synchronous write port
//               and the free-running +1 PC incrementer.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_pc (
    input  logic        CLOCK_50,
    input  logic        RESET_n,
    input  logic [3:0]  IR_ARn,
    input  logic [3:0]  IR_ARs,
    input  logic [3:0]  IR_ARm,
    input  logic [3:0]  mux_ARd_or_15,
    input  logic        CNTRL_write_en_ARd,
    input  logic [31:0] mux_ALU_result_or_DMEM_data,
    output logic [31:0] Rn,
    output logic [31:0] Rs,
    output logic [31:0] Rm,
    output logic [31:0] Rd,
    output logic [15:0] PC_out,
    output logic [15:0] PC_next
);

    localparam int          c_NUM_GPR = 15;
    localparam logic [3:0]  c_PC_ADDR = 4'd15;

    logic [31:0] r_regs [c_NUM_GPR];
    logic [15:0] r_pc;
    logic [31:0] w_view [16];
    logic [15:0] w_pc_next;
    logic        w_pc_write;

    assign w_pc_next  = r_pc + 16'd1;
    assign w_pc_write = CNTRL_write_en_ARd && (mux_ARd_or_15 == c_PC_ADDR);

    generate
        for (genvar i = 0; i < c_NUM_GPR; i++) begin : g_regs
            always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
                if (!RESET_n) begin
                    r_regs[i] <= '0;
                end else if (CNTRL_write_en_ARd && (mux_ARd_or_15 == 4'(i))) begin
                    r_regs[i] <= mux_ALU_result_or_DMEM_data;
                end
            end
            assign w_view[i] = r_regs[i];
        end
    endgenerate

    // An explicit write to R15 takes priority over the incrementer.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            r_pc <= '0;
        end else if (w_pc_write) begin
            r_pc <= mux_ALU_result_or_DMEM_data[15:0];
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign w_view[15] = {16'h0000, r_pc};

    assign Rn      = w_view[IR_ARn];
    assign Rs      = w_view[IR_ARs];
    assign Rm      = w_view[IR_ARm];
    assign Rd      = w_view[mux_ARd_or_15];
    assign PC_out  = r_pc;
    assign PC_next = w_pc_next;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_pc
// Description : Directed self-checking bench for reg_file_pc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_pc;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ar_n, ar_s, ar_m, ar_d;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rn, rs, rm, rd;
    logic [15:0] pc_out, pc_next;

    int n_checks = 0;
    int n_fails  = 0;

    reg_file_pc dut (
        .CLOCK_50                    (clk),
        .RESET_n                     (rst_n),
        .IR_ARn                      (ar_n),
        .IR_ARs                      (ar_s),
        .IR_ARm                      (ar_m),
        .mux_ARd_or_15               (ar_d),
        .CNTRL_write_en_ARd          (we),
        .mux_ALU_result_or_DMEM_data (wdata),
        .Rn                          (rn),
        .Rs                          (rs),
        .Rm                          (rm),
        .Rd                          (rd),
        .PC_out                      (pc_out),
        .PC_next                     (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        ar_d  = a;
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        wdata = '0;
        ar_n  = 4'd0; ar_s = 4'd1; ar_m = 4'd2; ar_d = 4'd3;

        // Reset held: outputs cleared, reset dominates clock
        tick(2);
        check("rst_pc_out",  {16'h0, pc_out},  32'h0);
        check("rst_pc_next", {16'h0, pc_next}, 32'h1);
        check("rst_rn",      rn, 32'h0);
        check("rst_rd",      rd, 32'h0);

        #2 rst_n = 1'b1;
        tick(3);
        check("pc_after_3", {16'h0, pc_out}, 32'd3);

        // Write sequence, PC runs 3 -> 7
        write_reg(4'd7, 32'd19);
        write_reg(4'd3, 32'd21);
        write_reg(4'd4, 32'd20);
        write_reg(4'd2, 32'd27);
        ar_n = 4'd7; ar_s = 4'd3; ar_m = 4'd4; ar_d = 4'd2;
        #1;
        check("seq_rn", rn, 32'd19);
        check("seq_rs", rs, 32'd21);
        check("seq_rm", rm, 32'd20);
        check("seq_rd", rd, 32'd27);
        ar_n = 4'd3; ar_s = 4'd4; ar_m = 4'd2;
        #1;
        check("seq2_rn", rn, 32'd21);
        check("seq2_rs", rs, 32'd20);
        check("seq2_rm", rm, 32'd27);
        check("seq_pc",  {16'h0, pc_out}, 32'd7);

        // PC write via R15 discards upper half
        ar_n = 4'd15;
        write_reg(4'd15, 32'hABCD_0002);
        check("pcw_pc",   {16'h0, pc_out}, 32'd2);
        check("pcw_r15",  rn, 32'h0000_0002);
        tick(1);
        check("pcw_pc3",  {16'h0, pc_out}, 32'd3);
        tick(1);
        check("pcw_pc4",  {16'h0, pc_out}, 32'd4);
        check("pcw_next", {16'h0, pc_next}, 32'd5);

        // Enable low for 5 edges
        write_reg(4'd5, 32'h0000_1234);     // pc -> 5
        ar_n  = 4'd5;
        ar_d  = 4'd5;
        wdata = 32'd55;
        we    = 1'b0;
        tick(5);
        check("wen0_r5", rn, 32'h0000_1234);
        check("wen0_pc", {16'h0, pc_out}, 32'd10);

        // Same-cycle read/write: no bypass
        write_reg(4'd6, 32'h66);            // pc -> 11
        ar_n = 4'd6; ar_s = 4'd6; ar_m = 4'd6; ar_d = 4'd6;
        wdata = 32'd77;
        we    = 1'b1;
        #1;
        check("rw_old", rn, 32'h66);
        tick(1);
        we = 1'b0;
        check("rw_rn", rn, 32'd77);
        check("rw_rs", rs, 32'd77);
        check("rw_rm", rm, 32'd77);
        check("rw_rd", rd, 32'd77);

        // PC wrap
        write_reg(4'd15, 32'h0000_FFFE);
        check("wrap_fffe", {16'h0, pc_out}, 32'h0000_FFFE);
        tick(1);
        check("wrap_ffff", {16'h0, pc_out}, 32'h0000_FFFF);
        check("wrap_nxt0", {16'h0, pc_next}, 32'h0000_0000);
        tick(1);
        check("wrap_zero", {16'h0, pc_out}, 32'h0000_0000);
        check("wrap_nxt1", {16'h0, pc_next}, 32'h0000_0001);

        // Reset mid-operation with a write pending
        ar_n = 4'd7; ar_s = 4'd2; ar_m = 4'd6; ar_d = 4'd7;
        wdata = 32'd99;
        we    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_r7",   rn, 32'h0);
        check("mrst_r2",   rs, 32'h0);
        check("mrst_r6",   rm, 32'h0);
        check("mrst_pc",   {16'h0, pc_out},  32'h0);
        check("mrst_next", {16'h0, pc_next}, 32'h1);
        tick(1);
        check("mrst_hold_r7", rd, 32'h0);
        check("mrst_hold_pc", {16'h0, pc_out}, 32'h0);
        we = 1'b0;
        #2 rst_n = 1'b1;
        tick(1);
        check("mrst_rel_pc", {16'h0, pc_out}, 32'd1);
        check("mrst_rel_r7", rn, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
